fitness_tracker_core: RTL

//  Parametrised step-tracker core that replaces the fixed-constant tracker. It conditions the raw

---
 rtl/fitness_tracker_core_if.sv | 35 +++
 rtl/fitness_tracker_core.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fitness_tracker_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : fitness_tracker_core_if
//  Purpose  : Groups the pulse input, the display controls and the metric
//             outputs of the step-tracker core into one bundle.
//  Signals  : pulse      raw step pulse (asynchronous to CLK)
//             mode_hold  1 = freeze display mode cycling
//             display    16-bit metric value (binary or packed BCD)
//             disp_mode  0 steps, 1 distance, 2 best streak, 3 high seconds
//             is_miles   distance metric on display
//             SI         step count on display is clamped
//             sec_tick   one-CLK pulse per second
//  Modports : master (pulse source / display driver side), slave (core)
//  Revision : 1.0  initial release
// ============================================================================
interface fitness_tracker_core_if;
    logic        pulse;
    logic        mode_hold;
    logic [15:0] display;
    logic [1:0]  disp_mode;
    logic        is_miles;
    logic        SI;
    logic        sec_tick;

    modport master (
        output pulse, mode_hold,
        input  display, disp_mode, is_miles, SI, sec_tick
    );

    modport slave (
        input  pulse, mode_hold,
        output display, disp_mode, is_miles, SI, sec_tick
    );
endinterface
`default_nettype wire

// File: rtl/fitness_tracker_core.sv
`default_nettype none
// ============================================================================
//  Module   : fitness_tracker_core
//  Purpose  : Parametrised step tracker. Synchronises and edge-detects the
//             raw step pulse, keeps total steps, distance, best over-rate
//             streak and credited high-activity seconds, and cycles the four
//             metrics onto a single 16-bit display bus once per DISP_SECS s.
//  Ports    : CLK    system clock, rising edge
//             reset  asynchronous active-high, clears all state
//             bus    fitness_tracker_core_if.slave (pulse, mode_hold in;
//                    display, disp_mode, is_miles, SI, sec_tick out)
//  Options  : FITBIT_BCD_EN  when defined, display carries 4 packed BCD
//             digits produced by a sequential double-dabble started on each
//             sec_tick (result visible 17 CLK after the tick).
//  Revision : 1.0  initial release
// ============================================================================
module fitness_tracker_core #(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned STEP_W      = 32,
    parameter int unsigned RATE_W      = 8,
    parameter int unsigned DIST_SHIFT  = 11,
    parameter int unsigned OVER_RATE   = 32,
    parameter int unsigned OVER_WINDOW = 9,
    parameter int unsigned HIGH_RATE   = 64,
    parameter int unsigned HIGH_MIN    = 60,
    parameter int unsigned DISP_SECS   = 2,
    parameter int unsigned DISP_MAX    = 9999
) (
    input  wire logic              CLK,
    input  wire logic              reset,
    fitness_tracker_core_if.slave  bus
);

    localparam int unsigned DIV_W  = $clog2(TICK_DIV);
    localparam int unsigned IDX_W  = $clog2(OVER_WINDOW + 1);
    localparam int unsigned MSEC_W = (DISP_SECS > 1) ? $clog2(DISP_SECS) : 1;
    // Comparison width wide enough for both the step counter and the display.
    localparam int unsigned CMP_W  = (STEP_W > 16) ? STEP_W : 16;

    localparam logic [STEP_W-1:0] STEP_MAX = '1;
    localparam logic [RATE_W-1:0] RATE_MAX = '1;

    function automatic logic [15:0] clamp_disp(input logic [CMP_W-1:0] v);
        if (v > CMP_W'(DISP_MAX)) begin
            clamp_disp = 16'(DISP_MAX);
        end else begin
            clamp_disp = v[15:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_q, div_d;
    logic              sync1_q, sync2_q, sync_prev_q;
    logic [STEP_W-1:0] total_q, total_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [IDX_W-1:0]  sec_idx_q, sec_idx_d;
    logic [15:0]       cur_run_q, cur_run_d;
    logic [15:0]       best_q, best_d;
    logic [15:0]       hi_run_q, hi_run_d;
    logic [15:0]       hi_total_q, hi_total_d;
    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       display_q;
    logic              is_miles_q;
    logic              si_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_tick;
    logic              w_step_evt;
    logic [RATE_W-1:0] w_rate;
    logic              w_in_window;
    logic              w_over;
    logic              w_high;
    logic [15:0]       w_run_inc;
    logic [15:0]       w_hi_inc;
    logic [16:0]       w_hi_sum_raw;
    logic [15:0]       w_hi_sum;
    logic [CMP_W-1:0]  w_sel;
    logic [15:0]       w_val;
    logic              w_miles;
    logic              w_si;

    assign w_tick     = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d      = w_tick ? '0 : div_q + DIV_W'(1);
    assign w_step_evt = sync2_q & ~sync_prev_q;

    // Closing-second rate includes a step that lands on the tick cycle.
    assign w_rate = (w_step_evt && (rate_q != RATE_MAX)) ? rate_q + RATE_W'(1) : rate_q;

    assign w_in_window  = (sec_idx_q < IDX_W'(OVER_WINDOW));
    assign w_over       = (32'(w_rate) >= OVER_RATE);
    assign w_high       = (32'(w_rate) >= HIGH_RATE);
    assign w_run_inc    = (cur_run_q == 16'hFFFF) ? cur_run_q : cur_run_q + 16'd1;
    assign w_hi_inc     = (hi_run_q == 16'hFFFF) ? hi_run_q : hi_run_q + 16'd1;
    assign w_hi_sum_raw = {1'b0, hi_total_q} + {1'b0, hi_run_q};
    assign w_hi_sum     = w_hi_sum_raw[16] ? 16'hFFFF : w_hi_sum_raw[15:0];

    always_comb begin
        total_d    = total_q;
        rate_d     = w_rate;
        sec_idx_d  = sec_idx_q;
        cur_run_d  = cur_run_q;
        best_d     = best_q;
        hi_run_d   = hi_run_q;
        hi_total_d = hi_total_q;
        msec_d     = msec_q;
        mode_d     = mode_q;

        if (w_step_evt && (total_q != STEP_MAX)) begin
            total_d = total_q + STEP_W'(1);
        end

        if (w_tick) begin
            rate_d = '0;

            // Streaks are only tracked inside the post-reset window; after
            // that, best stays frozen.
            if (w_in_window) begin
                sec_idx_d = sec_idx_q + IDX_W'(1);
                if (w_over) begin
                    cur_run_d = w_run_inc;
                    if (w_run_inc > best_q) begin
                        best_d = w_run_inc;
                    end
                end else begin
                    cur_run_d = '0;
                end
            end

            // A high-activity run is credited only when it ends.
            if (w_high) begin
                hi_run_d = w_hi_inc;
            end else begin
                if (hi_run_q >= 16'(HIGH_MIN)) begin
                    hi_total_d = w_hi_sum;
                end
                hi_run_d = '0;
            end

            if (!bus.mode_hold) begin
                if (msec_q == MSEC_W'(DISP_SECS - 1)) begin
                    msec_d = '0;
                    mode_d = mode_q + 2'd1;
                end else begin
                    msec_d = msec_q + MSEC_W'(1);
                end
            end
        end
    end

    // Metric selection and clamping
    always_comb begin
        w_sel = '0;
        unique case (mode_q)
            2'd0:    w_sel = CMP_W'(total_q);
            2'd1:    w_sel = CMP_W'(total_q >> DIST_SHIFT);
            2'd2:    w_sel = CMP_W'(best_q);
            default: w_sel = CMP_W'(hi_total_q);
        endcase
    end

    assign w_val   = clamp_disp(w_sel);
    assign w_miles = (mode_q == 2'd1);
    assign w_si    = (mode_q == 2'd0) && (CMP_W'(total_q) > CMP_W'(DISP_MAX));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            total_q     <= '0;
            rate_q      <= '0;
            sec_idx_q   <= '0;
            cur_run_q   <= '0;
            best_q      <= '0;
            hi_run_q    <= '0;
            hi_total_q  <= '0;
            msec_q      <= '0;
            mode_q      <= '0;
        end else begin
            div_q       <= div_d;
            sync1_q     <= bus.pulse;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            total_q     <= total_d;
            rate_q      <= rate_d;
            sec_idx_q   <= sec_idx_d;
            cur_run_q   <= cur_run_d;
            best_q      <= best_d;
            hi_run_q    <= hi_run_d;
            hi_total_q  <= hi_total_d;
            msec_q      <= msec_d;
            mode_q      <= mode_d;
        end
    end

`ifdef FITBIT_BCD_EN
    // ------------------------------------------------------------------
    // Sequential double-dabble: capture on tick, 16 shifts, then load.
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  bit_cnt_q;
    logic        miles_pend_q;
    logic        si_pend_q;
    logic [15:0] w_bcd_adj;
    logic        w_capture;
    logic        w_shift;
    logic        w_load;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        assign w_bcd_adj[4*g+3:4*g] = (bcd_q[4*g+3:4*g] >= 4'd5) ?
                                      bcd_q[4*g+3:4*g] + 4'd3 : bcd_q[4*g+3:4*g];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A tick always wins, restarting any conversion in flight.
    always_comb begin
        state_d = state_q;
        if (w_tick) begin
            state_d = ST_SHIFT;
        end else begin
            unique case (state_q)
                ST_SHIFT: if (bit_cnt_q == 4'd15) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_capture = w_tick;
        w_shift   = (state_q == ST_SHIFT) && !w_tick;
        w_load    = (state_q == ST_LOAD) && !w_tick;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            bin_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            miles_pend_q <= 1'b0;
            si_pend_q    <= 1'b0;
            display_q    <= '0;
            is_miles_q   <= 1'b0;
            si_q         <= 1'b0;
        end else begin
            if (w_capture) begin
                bin_q        <= w_val;
                bcd_q        <= '0;
                bit_cnt_q    <= '0;
                miles_pend_q <= w_miles;
                si_pend_q    <= w_si;
            end else if (w_shift) begin
                bcd_q     <= {w_bcd_adj[14:0], bin_q[15]};
                bin_q     <= {bin_q[14:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (w_load) begin
                display_q  <= bcd_q;
                is_miles_q <= miles_pend_q;
                si_q       <= si_pend_q;
            end
        end
    end
`else
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            display_q  <= '0;
            is_miles_q <= 1'b0;
            si_q       <= 1'b0;
        end else begin
            display_q  <= w_val;
            is_miles_q <= w_miles;
            si_q       <= w_si;
        end
    end
`endif

    assign bus.display   = display_q;
    assign bus.disp_mode = mode_q;
    assign bus.is_miles  = is_miles_q;
    assign bus.SI        = si_q;
    assign bus.sec_tick  = w_tick;

endmodule
`default_nettype wire
